// File: rtl/addr_translator_pkg.sv
// Shared state encoding and default geometry for the sample-to-bitmap address translator.
package addr_translator_pkg;

  localparam int DEFAULT_NUM_CHANNELS     = 2;
  localparam int DEFAULT_BAND_HALF_HEIGHT = 144;
  localparam int DEFAULT_WORDS_PER_ROW    = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SCALE   = 3'd3,
    ST_ADDR    = 3'd4,
    ST_OUTPUT  = 3'd5
  } state_t;

  // A single channel still needs a one-bit channel id
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_row_scaler.sv
// Maps a signed sample to a clamped pixel row inside its channel band; one register stage.
module sample_row_scaler
  import addr_translator_pkg::*;
#(
  parameter int SAMPLE_BITS      = 24,
  parameter int BAND_HALF_HEIGHT = DEFAULT_BAND_HALF_HEIGHT,
  parameter int NUM_CHANNELS     = DEFAULT_NUM_CHANNELS,
  parameter int ROW_W            = 14
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   en,
  input  logic signed [SAMPLE_BITS-1:0]          sample,
  input  logic [chan_width(NUM_CHANNELS)-1:0]    channel,
  output logic [ROW_W-1:0]                       row
);

  localparam int PW = SAMPLE_BITS + 32;
  localparam logic signed [PW-1:0] HALF = PW'(BAND_HALF_HEIGHT);
  localparam logic signed [PW-1:0] BAND = PW'(2 * BAND_HALF_HEIGHT);

  logic signed [PW-1:0] product, centred, band_top, band_bottom, clamped;

  // Product is kept at full width so the arithmetic shift sees every bit
  always_comb begin
    product     = PW'(sample) * HALF;
    band_top    = $signed(PW'(channel)) * BAND;
    band_bottom = band_top + BAND - PW'(1);
    centred     = band_top + HALF - (product >>> (SAMPLE_BITS - 1));
    clamped     = centred;
    if (centred < band_top) begin
      clamped = band_top;
    end else if (centred > band_bottom) begin
      clamped = band_bottom;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row <= '0;
    end else if (en) begin
      row <= ROW_W'(clamped);
    end
  end

endmodule

// File: rtl/multichannel_sample_to_memory_addr_translator.sv
// Turns multichannel FIFO frames into bitmap word/bit addresses, one per channel per column.
// Optional SAMPLE_DECIMATION_EN plots only every DECIMATION-th frame.
module multichannel_sample_to_memory_addr_translator
  import addr_translator_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int SAMPLE_BITS      = 24,
  parameter int NUM_CHANNELS     = DEFAULT_NUM_CHANNELS,
  parameter int BAND_HALF_HEIGHT = DEFAULT_BAND_HALF_HEIGHT,
  parameter int WORDS_PER_ROW    = DEFAULT_WORDS_PER_ROW,
  parameter int ADDRESS_LENGTH   = 14,
  parameter int DECIMATION       = 4
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   vsync,
  input  logic [DATA_WIDTH*NUM_CHANNELS-1:0]     fifo_data,
  input  logic                                   fifo_almost_empty,
  output logic                                   fifo_rd_en,
  output logic [ADDRESS_LENGTH-1:0]              word_address,
  output logic [4:0]                             bit_offset,
  output logic [chan_width(NUM_CHANNELS)-1:0]    channel_id,
  output logic                                   addr_valid,
  input  logic                                   addr_ready
);

  localparam int CH_W     = chan_width(NUM_CHANNELS);
  localparam int COLUMNS  = 32 * WORDS_PER_ROW;
  localparam int COL_W    = $clog2(COLUMNS);
  localparam int SLOT_LSB = DATA_WIDTH - SAMPLE_BITS;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);

  state_t state, next_state;
  logic signed [SAMPLE_BITS-1:0] samples [NUM_CHANNELS];
  logic [CH_W-1:0]           ch_idx;
  logic [COL_W-1:0]          column;
  logic [ADDRESS_LENGTH-1:0] row;
  logic vsync_d, vsync_pending, vsync_edge;
  logic handshake, frame_done, plot_frame;

`ifdef SAMPLE_DECIMATION_EN
  localparam int DEC_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIMATION - 1);
  logic [DEC_W-1:0] dec_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dec_count <= '0;
    end else if (state == ST_CAPTURE) begin
      dec_count <= (dec_count == DEC_LAST) ? '0 : dec_count + 1'b1;
    end
  end

  assign plot_frame = (dec_count == '0);
`else
  assign plot_frame = 1'b1;
`endif

  assign vsync_edge = vsync & ~vsync_d;
  assign handshake  = addr_valid & addr_ready;
  assign frame_done = handshake && (ch_idx == LAST_CH);

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (!fifo_almost_empty) next_state = ST_READ;
      ST_READ:    next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = plot_frame ? ST_SCALE : ST_IDLE;
      ST_SCALE:   next_state = ST_ADDR;
      ST_ADDR:    next_state = ST_OUTPUT;
      ST_OUTPUT:  if (handshake) next_state = (ch_idx == LAST_CH) ? ST_IDLE : ST_SCALE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Strobes are registered from next_state so they line up exactly with READ/OUTPUT
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      fifo_rd_en <= 1'b0;
      addr_valid <= 1'b0;
    end else begin
      state      <= next_state;
      fifo_rd_en <= (next_state == ST_READ);
      addr_valid <= (next_state == ST_OUTPUT);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CHANNELS; c++) samples[c] <= '0;
      ch_idx <= '0;
    end else if (state == ST_CAPTURE) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        samples[c] <= fifo_data[c*DATA_WIDTH + SLOT_LSB +: SAMPLE_BITS];
      end
      ch_idx <= '0;
    end else if (handshake && (ch_idx != LAST_CH)) begin
      ch_idx <= ch_idx + 1'b1;
    end
  end

  sample_row_scaler #(
    .SAMPLE_BITS      (SAMPLE_BITS),
    .BAND_HALF_HEIGHT (BAND_HALF_HEIGHT),
    .NUM_CHANNELS     (NUM_CHANNELS),
    .ROW_W            (ADDRESS_LENGTH)
  ) u_scaler (
    .clk     (clk),
    .resetn  (resetn),
    .en      (state == ST_SCALE),
    .sample  (samples[ch_idx]),
    .channel (ch_idx),
    .row     (row)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_address <= '0;
      bit_offset   <= '0;
      channel_id   <= '0;
    end else if (state == ST_ADDR) begin
      word_address <= ADDRESS_LENGTH'(32'(row) * 32'(WORDS_PER_ROW) + 32'(column >> 5));
      bit_offset   <= column[4:0];
      channel_id   <= ch_idx;
    end
  end

  // A pending or fresh vsync overrides the column step, so a coincident wrap yields 0 only once
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vsync_d       <= 1'b0;
      vsync_pending <= 1'b0;
      column        <= '0;
    end else begin
      vsync_d <= vsync;
      if ((frame_done || state == ST_IDLE) && (vsync_pending || vsync_edge)) begin
        column        <= '0;
        vsync_pending <= 1'b0;
      end else begin
        if (frame_done) column <= (column == LAST_COL) ? '0 : column + 1'b1;
        if (vsync_edge) vsync_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multichannel_sample_to_memory_addr_translator.sv
// Randomised self-checking bench for the address translator against an arithmetic row/column model.
module tb_multichannel_sample_to_memory_addr_translator;

  localparam int SB   = 24;
  localparam int H    = 144;
  localparam int WPR  = 24;
  localparam int COLS = 32 * WPR;
  localparam int NCH  = 2;
  localparam int DEC  = 4;

  logic        clk = 1'b0;
  logic        resetn, vsync, fifo_almost_empty, addr_ready;
  logic [63:0] fifo_data;
  logic        fifo_rd_en, addr_valid;
  logic [13:0] word_address;
  logic [4:0]  bit_offset;
  logic        channel_id;

  int tests_run = 0, tests_failed = 0;
  int rd_count = 0, acc_count = 0;
  int model_col, model_dec;
  bit model_pending, last_plotted;
  int obs_addr [NCH];
  int obs_bit  [NCH];
  int obs_ch   [NCH];

  multichannel_sample_to_memory_addr_translator dut (
    .clk               (clk),
    .resetn            (resetn),
    .vsync             (vsync),
    .fifo_data         (fifo_data),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_rd_en        (fifo_rd_en),
    .word_address      (word_address),
    .bit_offset        (bit_offset),
    .channel_id        (channel_id),
    .addr_valid        (addr_valid),
    .addr_ready        (addr_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) rd_count++;
    if (addr_valid && addr_ready) acc_count++;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, actual still running, required done");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Row from the plotting rule using floor division instead of shifts
  function automatic int modelRow(input logic [23:0] raw, input int c);
    longint s, p, q, r, lo, hi, d;
    s = longint'($signed(raw));
    d = longint'(1) << (SB - 1);
    p = s * H;
    if (p >= 0) q = p / d;
    else        q = -((-p + d - 1) / d);
    lo = c * 2 * H;
    hi = lo + 2 * H - 1;
    r  = lo + H - q;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return int'(r);
  endfunction

  function automatic logic [23:0] randSample();
    case ($urandom_range(0, 7))
      0:       return 24'h7FFFFF;
      1:       return 24'h800000;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic resetDut();
    resetn            = 1'b0;
    vsync             = 1'b0;
    fifo_almost_empty = 1'b1;
    addr_ready        = 1'b0;
    fifo_data         = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    model_col     = 0;
    model_pending = 0;
    model_dec     = 0;
  endtask

  task automatic applyStimulus(input logic [23:0] s0, input logic [23:0] s1, input int stall, input bit pulse_vsync);
    int lat, waited, rd_before, acc_before, row_exp, addr_exp, seen;
    bit plot;
    logic [23:0] smp [NCH];
    smp[0] = s0;
    smp[1] = s1;
    fifo_data = {s1, 8'($urandom), s0, 8'($urandom)};
    rd_before = rd_count;
`ifdef SAMPLE_DECIMATION_EN
    plot = (model_dec == 0);
    model_dec = (model_dec + 1) % DEC;
`else
    plot = 1'b1;
`endif
    last_plotted = plot;
    fifo_almost_empty = 1'b0;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!fifo_rd_en && waited < 20);
    fifo_almost_empty = 1'b1;
    checkOutput("rd_en_pulse", fifo_rd_en, 1);
    if (pulse_vsync) begin
      vsync = 1'b1;
      model_pending = 1'b1;
    end
    if (!plot) begin
      seen = 0;
      repeat (10) begin
        @(negedge clk);
        vsync = 1'b0;
        if (addr_valid) seen++;
      end
      checkOutput("skip_no_valid", seen, 0);
      checkOutput("skip_one_read", rd_count, rd_before + 1);
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      acc_before = acc_count;
      lat = 0;
      do begin @(negedge clk); lat++; vsync = 1'b0; end while (!addr_valid && lat < 20);
      if (c == 0) checkOutput("latency", lat, 4);
      row_exp  = modelRow(smp[c], c);
      addr_exp = row_exp * WPR + model_col / 32;
      obs_addr[c] = int'(word_address);
      obs_bit[c]  = int'(bit_offset);
      obs_ch[c]   = int'(channel_id);
      checkOutput("addr_valid", addr_valid, 1);
      checkOutput("word_address", word_address, addr_exp);
      checkOutput("bit_offset", bit_offset, model_col % 32);
      checkOutput("channel_id", channel_id, c);
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        checkOutput("stall_valid", addr_valid, 1);
        checkOutput("stall_addr", word_address, addr_exp);
        checkOutput("stall_bit", bit_offset, model_col % 32);
      end
      if (stall > 0) checkOutput("stall_no_read", rd_count, rd_before + 1);
      addr_ready = 1'b1;
      @(negedge clk);
      addr_ready = 1'b0;
      checkOutput("accept_once", acc_count, acc_before + 1);
    end
    checkOutput("frame_one_read", rd_count, rd_before + 1);
    if (model_pending) begin
      model_col     = 0;
      model_pending = 0;
    end else begin
      model_col = (model_col + 1) % COLS;
    end
  endtask

  initial begin
    int waited, acc_before, rd_before;
    int plotted [$];

    resetDut();
    resetn = 1'b0;
    #1;
    checkOutput("reset_rd_en", fifo_rd_en, 0);
    checkOutput("reset_valid", addr_valid, 0);
    checkOutput("reset_addr", word_address, 0);
    checkOutput("reset_bit", bit_offset, 0);
    checkOutput("reset_ch", channel_id, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset while an address is being offered
    fifo_data = {32'h12345600, 32'h00ABCD00};
    fifo_almost_empty = 1'b0;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!fifo_rd_en && waited < 20);
    fifo_almost_empty = 1'b1;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!addr_valid && waited < 20);
    checkOutput("mid_valid_before", addr_valid, 1);
    acc_before = acc_count;
    resetn = 1'b0;
    #1;
    checkOutput("mid_reset_valid", addr_valid, 0);
    checkOutput("mid_reset_addr", word_address, 0);
    checkOutput("mid_reset_rd_en", fifo_rd_en, 0);
    resetDut();
    repeat (4) @(negedge clk);
    checkOutput("mid_reset_idle", addr_valid, 0);
    checkOutput("mid_reset_no_accept", acc_count, acc_before);

`ifdef SAMPLE_DECIMATION_EN
    rd_before  = rd_count;
    acc_before = acc_count;
    for (int f = 0; f < 8; f++) begin
      applyStimulus(24'h0, 24'h0, 0, 0);
      if (last_plotted) plotted.push_back(obs_bit[0]);
    end
    checkOutput("dec_reads", rd_count - rd_before, 8);
    checkOutput("dec_accepts", acc_count - acc_before, 4);
    checkOutput("dec_plotted", plotted.size(), 2);
    if (plotted.size() == 2) begin
      checkOutput("dec_col0", plotted[0], 0);
      checkOutput("dec_col1", plotted[1], 1);
    end
    for (int f = 0; f < 40; f++) applyStimulus(randSample(), randSample(), $urandom_range(0, 3), 0);
`else
    rd_before = rd_count;
    applyStimulus(24'h0, 24'h0, 0, 0);
    checkOutput("zero_ch0_addr", obs_addr[0], 3456);
    checkOutput("zero_ch1_addr", obs_addr[1], 10368);
    checkOutput("zero_ch1_id", obs_ch[1], 1);
    applyStimulus(24'h7FFFFF, 24'h0, 0, 0);
    checkOutput("max_pos_addr", obs_addr[0], 24);
    applyStimulus(24'h800000, 24'h0, 0, 0);
    checkOutput("max_neg_addr", obs_addr[0], 6888);
    for (int f = 4; f <= 38; f++) applyStimulus(24'h0, 24'h0, (f == 10) ? 3 : 0, 0);
    checkOutput("frame38_addr", obs_addr[0], 3457);
    checkOutput("frame38_bit", obs_bit[0], 5);
    for (int f = 39; f <= COLS; f++) applyStimulus(randSample(), randSample(), $urandom_range(0, 3), 0);
    checkOutput("total_reads", rd_count - rd_before, COLS);
    applyStimulus(24'h0, 24'h0, 0, 0);
    checkOutput("wrap_addr", obs_addr[0], 3456);
    checkOutput("wrap_bit", obs_bit[0], 0);
    for (int f = 0; f < 99; f++) applyStimulus(randSample(), randSample(), $urandom_range(0, 2), 0);
    applyStimulus(randSample(), randSample(), 0, 1);
    checkOutput("vsync_frame_col100", obs_bit[0], 4);
    applyStimulus(24'h0, 24'h0, 0, 0);
    checkOutput("vsync_next_addr", obs_addr[0], 3456);
    checkOutput("vsync_next_bit", obs_bit[0], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
